// File: rtl/id_ex_stage_pkg.sv
// Shared widths, ALU function codes and register constants for the ID/EX stage.
package id_ex_stage_pkg;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned FW = 4;

  localparam logic [AW-1:0] REG_ZERO = '0;

  localparam logic [FW-1:0] FUNC_PASSB = 4'b0000;
  localparam logic [FW-1:0] FUNC_ADD   = 4'b0010;
  localparam logic [FW-1:0] FUNC_SUB   = 4'b0100;
  localparam logic [FW-1:0] FUNC_LUI   = 4'b1100;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Three-way priority operand select: EX/MEM result, then MEM/WB data, then the
// registered read data. Register zero is never forwarded.
module fwd_mux
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned DW = id_ex_stage_pkg::DW,
  parameter int unsigned AW = id_ex_stage_pkg::AW
) (
  input  logic [AW-1:0] src_addr,
  input  logic [DW-1:0] reg_data,
  input  logic          mem_reg_write,
  input  logic [AW-1:0] mem_wr_addr,
  input  logic [DW-1:0] mem_data,
  input  logic          wb_reg_write,
  input  logic [AW-1:0] wb_wr_addr,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] fwd_data
);

  logic mem_hit;
  logic wb_hit;

  always_comb begin
    mem_hit = mem_reg_write & (mem_wr_addr != AW'(REG_ZERO)) & (mem_wr_addr == src_addr);
    wb_hit  = wb_reg_write  & (wb_wr_addr  != AW'(REG_ZERO)) & (wb_wr_addr  == src_addr);
    fwd_data = reg_data;
    if (mem_hit) begin
      fwd_data = mem_data;
    end else if (wb_hit) begin
      fwd_data = wb_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: load-use stall detection, bubble
// insertion on stall/flush, and EX/MEM / MEM/WB operand forwarding.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned DW = id_ex_stage_pkg::DW,
  parameter int unsigned AW = id_ex_stage_pkg::AW,
  parameter int unsigned FW = id_ex_stage_pkg::FW
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ID_Valid,
  input  logic [AW-1:0] ID_RsAddr,
  input  logic [AW-1:0] ID_RtAddr,
  input  logic [DW-1:0] ID_RsData,
  input  logic [DW-1:0] ID_RtData,
  input  logic [DW-1:0] ID_Imm,
  input  logic          ID_UseImm,
  input  logic [FW-1:0] ID_Func,
  input  logic [AW-1:0] ID_WrAddr,
  input  logic          ID_RegWrite,
  input  logic          ID_MemRead,
  input  logic          Flush,
  input  logic          MEM_RegWrite,
  input  logic [AW-1:0] MEM_WrAddr,
  input  logic [DW-1:0] MEM_Data,
  input  logic          WB_RegWrite,
  input  logic [AW-1:0] WB_WrAddr,
  input  logic [DW-1:0] WB_Data,
  output logic [DW-1:0] ALU_DA,
  output logic [DW-1:0] ALU_DB,
  output logic [FW-1:0] ALU_Func,
  output logic          EX_Valid,
  output logic [AW-1:0] EX_WrAddr,
  output logic          EX_RegWrite,
  output logic          EX_MemRead,
  output logic [DW-1:0] EX_StoreData,
  output logic          Stall
);

  logic          valid_q,     valid_d;
  logic [AW-1:0] rs_addr_q,   rs_addr_d;
  logic [AW-1:0] rt_addr_q,   rt_addr_d;
  logic [DW-1:0] rs_data_q,   rs_data_d;
  logic [DW-1:0] rt_data_q,   rt_data_d;
  logic [DW-1:0] imm_q,       imm_d;
  logic          use_imm_q,   use_imm_d;
  logic [FW-1:0] func_q,      func_d;
  logic [AW-1:0] wr_addr_q,   wr_addr_d;
  logic          reg_write_q, reg_write_d;
  logic          mem_read_q,  mem_read_d;

  logic          load_use;
  logic          bubble;
  logic [DW-1:0] fwd_rs;
  logic [DW-1:0] fwd_rt;

  always_comb begin
    load_use = ID_Valid & valid_q & mem_read_q & (wr_addr_q != AW'(REG_ZERO)) &
               ((ID_RsAddr == wr_addr_q) | (ID_RtAddr == wr_addr_q));
    // Flush and stall both collapse to the same bubble; stall still reports.
    bubble = Flush | load_use;
  end

  always_comb begin
    valid_d     = 1'b0;
    rs_addr_d   = '0;
    rt_addr_d   = '0;
    rs_data_d   = '0;
    rt_data_d   = '0;
    imm_d       = '0;
    use_imm_d   = 1'b0;
    func_d      = FW'(FUNC_PASSB);
    wr_addr_d   = '0;
    reg_write_d = 1'b0;
    mem_read_d  = 1'b0;
    if (!bubble) begin
      valid_d     = ID_Valid;
      rs_addr_d   = ID_RsAddr;
      rt_addr_d   = ID_RtAddr;
      rs_data_d   = ID_RsData;
      rt_data_d   = ID_RtData;
      imm_d       = ID_Imm;
      use_imm_d   = ID_UseImm;
      func_d      = ID_Func;
      wr_addr_d   = ID_WrAddr;
      reg_write_d = ID_RegWrite;
      mem_read_d  = ID_MemRead;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q     <= 1'b0;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      use_imm_q   <= 1'b0;
      func_q      <= '0;
      wr_addr_q   <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rs_addr_q   <= rs_addr_d;
      rt_addr_q   <= rt_addr_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      imm_q       <= imm_d;
      use_imm_q   <= use_imm_d;
      func_q      <= func_d;
      wr_addr_q   <= wr_addr_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
    end
  end

  fwd_mux #(.DW(DW), .AW(AW)) u_fwd_rs (
    .src_addr      (rs_addr_q),
    .reg_data      (rs_data_q),
    .mem_reg_write (MEM_RegWrite),
    .mem_wr_addr   (MEM_WrAddr),
    .mem_data      (MEM_Data),
    .wb_reg_write  (WB_RegWrite),
    .wb_wr_addr    (WB_WrAddr),
    .wb_data       (WB_Data),
    .fwd_data      (fwd_rs)
  );

  fwd_mux #(.DW(DW), .AW(AW)) u_fwd_rt (
    .src_addr      (rt_addr_q),
    .reg_data      (rt_data_q),
    .mem_reg_write (MEM_RegWrite),
    .mem_wr_addr   (MEM_WrAddr),
    .mem_data      (MEM_Data),
    .wb_reg_write  (WB_RegWrite),
    .wb_wr_addr    (WB_WrAddr),
    .wb_data       (WB_Data),
    .fwd_data      (fwd_rt)
  );

  always_comb begin
    ALU_DA       = fwd_rs;
    ALU_DB       = use_imm_q ? imm_q : fwd_rt;
    ALU_Func     = func_q;
    EX_Valid     = valid_q;
    EX_WrAddr    = wr_addr_q;
    EX_RegWrite  = reg_write_q & valid_q;
    EX_MemRead   = mem_read_q & valid_q;
    EX_StoreData = fwd_rt;
    Stall        = load_use;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Vector-table bench for id_ex_stage with a queue scoreboard of expected EX outputs.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ID_Valid;
  logic [4:0]  ID_RsAddr, ID_RtAddr, ID_WrAddr;
  logic [31:0] ID_RsData, ID_RtData, ID_Imm;
  logic        ID_UseImm;
  logic [3:0]  ID_Func;
  logic        ID_RegWrite, ID_MemRead, Flush;
  logic        MEM_RegWrite, WB_RegWrite;
  logic [4:0]  MEM_WrAddr, WB_WrAddr;
  logic [31:0] MEM_Data, WB_Data;
  logic [31:0] ALU_DA, ALU_DB, EX_StoreData;
  logic [3:0]  ALU_Func;
  logic        EX_Valid, EX_RegWrite, EX_MemRead, Stall;
  logic [4:0]  EX_WrAddr;

  id_ex_stage #(.DW(32), .AW(5), .FW(4)) dut (
    .CLK(CLK), .RST(RST),
    .ID_Valid(ID_Valid), .ID_RsAddr(ID_RsAddr), .ID_RtAddr(ID_RtAddr),
    .ID_RsData(ID_RsData), .ID_RtData(ID_RtData), .ID_Imm(ID_Imm),
    .ID_UseImm(ID_UseImm), .ID_Func(ID_Func), .ID_WrAddr(ID_WrAddr),
    .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .Flush(Flush),
    .MEM_RegWrite(MEM_RegWrite), .MEM_WrAddr(MEM_WrAddr), .MEM_Data(MEM_Data),
    .WB_RegWrite(WB_RegWrite), .WB_WrAddr(WB_WrAddr), .WB_Data(WB_Data),
    .ALU_DA(ALU_DA), .ALU_DB(ALU_DB), .ALU_Func(ALU_Func), .EX_Valid(EX_Valid),
    .EX_WrAddr(EX_WrAddr), .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
    .EX_StoreData(EX_StoreData), .Stall(Stall)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        v;   logic [4:0] rs;  logic [4:0] rt;
    logic [31:0] rsd; logic [31:0] rtd; logic [31:0] imm;
    logic        ui;  logic [3:0] fn;  logic [4:0] wa;
    logic        rw;  logic mr;        logic fl;
    logic        mrw; logic [4:0] mwa; logic [31:0] md;
    logic        wrw; logic [4:0] wwa; logic [31:0] wd;
    logic        e_stall;
    logic [31:0] e_da; logic [31:0] e_db; logic [31:0] e_st;
    logic [3:0]  e_fn; logic e_v; logic e_rw; logic e_mr; logic [4:0] e_wa;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] da; logic [31:0] db; logic [31:0] st;
    logic [3:0]  fn; logic v; logic rw; logic mr; logic [4:0] wa;
  } exp_t;

  localparam int NV = 17;
  vec_t vt [NV];
  exp_t sb_q [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ALU_DA"},       ALU_DA, 32'h0);
    check({tag, " ALU_DB"},       ALU_DB, 32'h0);
    check({tag, " ALU_Func"},     32'(ALU_Func), 32'h0);
    check({tag, " EX_Valid"},     32'(EX_Valid), 32'h0);
    check({tag, " EX_WrAddr"},    32'(EX_WrAddr), 32'h0);
    check({tag, " EX_RegWrite"},  32'(EX_RegWrite), 32'h0);
    check({tag, " EX_MemRead"},   32'(EX_MemRead), 32'h0);
    check({tag, " EX_StoreData"}, EX_StoreData, 32'h0);
    check({tag, " Stall"},        32'(Stall), 32'h0);
  endtask

  task automatic drive_id(input vec_t x);
    ID_Valid = x.v;   ID_RsAddr = x.rs;  ID_RtAddr = x.rt;
    ID_RsData = x.rsd; ID_RtData = x.rtd; ID_Imm = x.imm;
    ID_UseImm = x.ui; ID_Func = x.fn;    ID_WrAddr = x.wa;
    ID_RegWrite = x.rw; ID_MemRead = x.mr; Flush = x.fl;
  endtask

  task automatic drive_fwd(input vec_t x);
    MEM_RegWrite = x.mrw; MEM_WrAddr = x.mwa; MEM_Data = x.md;
    WB_RegWrite  = x.wrw; WB_WrAddr  = x.wwa; WB_Data  = x.wd;
  endtask

  initial begin
    vec_t z;
    exp_t e;
    string t;

    // ID fields | MEM/WB during EX | expected Stall, DA, DB, StoreData, Func, Valid, RegWrite, MemRead, WrAddr
    vt[0]  = '{1'b1,5'd1,5'd2,32'd5,32'd7,32'd0,1'b0,FUNC_ADD,5'd3,1'b1,1'b0,1'b0,
               1'b0,5'd0,32'd0,1'b0,5'd0,32'd0, 1'b0,32'd5,32'd7,32'd7,FUNC_ADD,1'b1,1'b1,1'b0,5'd3};
    vt[1]  = '{1'b1,5'd1,5'd2,32'd1,32'd2,32'd0,1'b0,FUNC_ADD,5'd5,1'b1,1'b0,1'b0,
               1'b1,5'd1,32'h100,1'b1,5'd1,32'h200, 1'b0,32'h100,32'd2,32'd2,FUNC_ADD,1'b1,1'b1,1'b0,5'd5};
    vt[2]  = '{1'b1,5'd6,5'd0,32'h10,32'd0,32'd8,1'b1,FUNC_ADD,5'd4,1'b1,1'b1,1'b0,
               1'b0,5'd0,32'd0,1'b0,5'd0,32'd0, 1'b0,32'h10,32'd8,32'd0,FUNC_ADD,1'b1,1'b1,1'b1,5'd4};
    vt[3]  = '{1'b1,5'd4,5'd2,32'd0,32'd9,32'd0,1'b0,FUNC_SUB,5'd7,1'b1,1'b0,1'b0,
               1'b0,5'd0,32'd0,1'b0,5'd0,32'd0, 1'b1,32'd0,32'd0,32'd0,FUNC_PASSB,1'b0,1'b0,1'b0,5'd0};
    vt[4]  = '{1'b1,5'd4,5'd2,32'd0,32'd9,32'd0,1'b0,FUNC_SUB,5'd7,1'b1,1'b0,1'b0,
               1'b0,5'd0,32'd0,1'b1,5'd4,32'h44, 1'b0,32'h44,32'd9,32'd9,FUNC_SUB,1'b1,1'b1,1'b0,5'd7};
    vt[5]  = '{1'b1,5'd0,5'd0,32'd0,32'd3,32'd0,1'b0,FUNC_ADD,5'd8,1'b1,1'b0,1'b0,
               1'b1,5'd0,32'hDEAD,1'b1,5'd0,32'hDEAD, 1'b0,32'd0,32'd3,32'd3,FUNC_ADD,1'b1,1'b1,1'b0,5'd8};
    vt[6]  = '{1'b1,5'd1,5'd9,32'h11,32'h22,32'h1234,1'b1,FUNC_LUI,5'd9,1'b1,1'b0,1'b0,
               1'b1,5'd9,32'h55,1'b1,5'd9,32'h66, 1'b0,32'h11,32'h1234,32'h55,FUNC_LUI,1'b1,1'b1,1'b0,5'd9};
    vt[7]  = '{1'b1,5'd1,5'd2,32'd3,32'd4,32'd0,1'b0,FUNC_ADD,5'd3,1'b1,1'b0,1'b1,
               1'b0,5'd0,32'd0,1'b0,5'd0,32'd0, 1'b0,32'd0,32'd0,32'd0,FUNC_PASSB,1'b0,1'b0,1'b0,5'd0};
    vt[8]  = '{1'b1,5'd2,5'd3,32'd1,32'd2,32'd0,1'b0,FUNC_ADD,5'd5,1'b1,1'b1,1'b0,
               1'b0,5'd0,32'd0,1'b0,5'd0,32'd0, 1'b0,32'd1,32'd2,32'd2,FUNC_ADD,1'b1,1'b1,1'b1,5'd5};
    vt[9]  = '{1'b1,5'd5,5'd1,32'd0,32'd0,32'd0,1'b0,FUNC_SUB,5'd6,1'b1,1'b0,1'b1,
               1'b0,5'd0,32'd0,1'b0,5'd0,32'd0, 1'b1,32'd0,32'd0,32'd0,FUNC_PASSB,1'b0,1'b0,1'b0,5'd0};
    vt[10] = '{1'b1,5'd3,5'd6,32'hA,32'hB,32'd0,1'b0,FUNC_ADD,5'd10,1'b1,1'b0,1'b0,
               1'b1,5'd7,32'h99,1'b1,5'd6,32'h77, 1'b0,32'hA,32'h77,32'h77,FUNC_ADD,1'b1,1'b1,1'b0,5'd10};
    vt[11] = '{1'b1,5'd1,5'd2,32'd3,32'd4,32'd0,1'b0,FUNC_ADD,5'd12,1'b1,1'b1,1'b0,
               1'b0,5'd0,32'd0,1'b0,5'd0,32'd0, 1'b0,32'd3,32'd4,32'd4,FUNC_ADD,1'b1,1'b1,1'b1,5'd12};
    vt[12] = '{1'b0,5'd12,5'd0,32'd5,32'd6,32'd0,1'b0,FUNC_SUB,5'd13,1'b1,1'b1,1'b0,
               1'b0,5'd0,32'd0,1'b0,5'd0,32'd0, 1'b0,32'd5,32'd6,32'd6,FUNC_SUB,1'b0,1'b0,1'b0,5'd13};
    vt[13] = '{1'b1,5'd1,5'd2,32'd3,32'd4,32'd0,1'b0,FUNC_ADD,5'd0,1'b1,1'b1,1'b0,
               1'b0,5'd0,32'd0,1'b0,5'd0,32'd0, 1'b0,32'd3,32'd4,32'd4,FUNC_ADD,1'b1,1'b1,1'b1,5'd0};
    vt[14] = '{1'b1,5'd0,5'd0,32'd0,32'd8,32'd0,1'b0,FUNC_ADD,5'd14,1'b1,1'b0,1'b0,
               1'b0,5'd0,32'd0,1'b0,5'd0,32'd0, 1'b0,32'd0,32'd8,32'd8,FUNC_ADD,1'b1,1'b1,1'b0,5'd14};
    vt[15] = '{1'b1,5'd1,5'd2,32'd3,32'd4,32'd0,1'b0,FUNC_ADD,5'd9,1'b1,1'b1,1'b0,
               1'b0,5'd0,32'd0,1'b0,5'd0,32'd0, 1'b0,32'd3,32'd4,32'd4,FUNC_ADD,1'b1,1'b1,1'b1,5'd9};
    vt[16] = '{1'b1,5'd2,5'd9,32'd0,32'd0,32'd0,1'b0,FUNC_ADD,5'd11,1'b1,1'b0,1'b0,
               1'b0,5'd0,32'd0,1'b0,5'd0,32'd0, 1'b1,32'd0,32'd0,32'd0,FUNC_PASSB,1'b0,1'b0,1'b0,5'd0};

    z = vt[0];
    z.v = 1'b0; z.rw = 1'b0; z.mr = 1'b0; z.fl = 1'b0;
    z.mrw = 1'b0; z.wrw = 1'b0;
    RST = 1'b1;
    drive_id(z);
    drive_fwd(z);

    #7;
    check_all_zero("reset");
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    for (int i = 0; i < NV; i++) begin
      drive_id(vt[i]);
      #1;
      check($sformatf("v%0d Stall", i), 32'(Stall), 32'(vt[i].e_stall));
      e.idx = i;      e.da = vt[i].e_da; e.db = vt[i].e_db; e.st = vt[i].e_st;
      e.fn = vt[i].e_fn; e.v = vt[i].e_v; e.rw = vt[i].e_rw; e.mr = vt[i].e_mr;
      e.wa = vt[i].e_wa;
      sb_q.push_back(e);
      @(posedge CLK);
      drive_fwd(vt[i]);
      #1;
      if (sb_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL scoreboard v%0d: got empty queue, expected an entry", i);
      end else begin
        e = sb_q.pop_front();
        t = $sformatf("v%0d", e.idx);
        check({t, " ALU_DA"},       ALU_DA, e.da);
        check({t, " ALU_DB"},       ALU_DB, e.db);
        check({t, " EX_StoreData"}, EX_StoreData, e.st);
        check({t, " ALU_Func"},     32'(ALU_Func), 32'(e.fn));
        check({t, " EX_Valid"},     32'(EX_Valid), 32'(e.v));
        check({t, " EX_RegWrite"},  32'(EX_RegWrite), 32'(e.rw));
        check({t, " EX_MemRead"},   32'(EX_MemRead), 32'(e.mr));
        check({t, " EX_WrAddr"},    32'(EX_WrAddr), 32'(e.wa));
      end
    end

    // Reset asserted while a load-use stall is pending, with no clock edge.
    drive_id(vt[11]);
    @(posedge CLK);
    #1;
    z = vt[12];
    z.v = 1'b1;
    drive_id(z);
    #1;
    check("midrst Stall before", 32'(Stall), 32'h1);
    RST = 1'b1;
    #1;
    check_all_zero("midrst");
    #1;
    RST = 1'b0;
    @(posedge CLK);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
